// File: rtl/register_file_param.sv
// register_file_param
// Parameterised register file: two registered read ports sharing one read
// strobe, one write port with per-byte enables, and a one-bit-per-register
// "pending" scoreboard (set by a reserve strobe, cleared by a write).
//
// Optional build macro REGFILE_BYPASS_EN:
//   defined   - a read that hits the register being written on the same edge
//               returns the byte-merged new value (write-to-read forwarding).
//   undefined - that read returns the value held before the write; the new
//               value shows up on the next read.
//
// With ZERO_REG != 0, index 0 reads as zero, ignores writes and never
// becomes busy.

module register_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   readReg1,
  input  logic [ADDR_W-1:0]   readReg2,
  input  logic                readEn,
  input  logic [ADDR_W-1:0]   writeReg,
  input  logic                writeEn,
  input  logic [DATA_W-1:0]   writeData,
  input  logic [DATA_W/8-1:0] byteEn,
  input  logic                rsvEn,
  input  logic [ADDR_W-1:0]   rsvReg,
  output logic [DATA_W-1:0]   outReg1,
  output logic [DATA_W-1:0]   outReg2,
  output logic                outValid,
  output logic                busy1,
  output logic                busy2
);

  localparam int DEPTH    = 2 ** ADDR_W;
  localparam int NBYTES   = DATA_W / 8;
  localparam bit HardZero = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busyNext;

  logic [DATA_W-1:0] byteMask;
  logic [DATA_W-1:0] writeOld;
  logic [DATA_W-1:0] mergedData;
  logic              writeAny;
  logic              writeStore;
  logic              rsvSet;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;

  // Expand the byte enables into a bit mask over the data word.
  always_comb begin
    byteMask = '0;
    for (int k = 0; k < NBYTES; k++) begin
      byteMask[8*k +: 8] = {8{byteEn[k]}};
    end
  end

  // Merge new bytes over the current contents of the write target.
  always_comb begin
    writeOld   = regs[writeReg];
    mergedData = (writeOld & ~byteMask) | (writeData & byteMask);
  end

  // A write with no enabled bytes is a no-op, both for data and scoreboard;
  // the hardwired zero register additionally never stores or reserves.
  always_comb begin
    writeAny   = writeEn && (|byteEn);
    writeStore = writeAny && !(HardZero && (writeReg == '0));
    rsvSet     = rsvEn && !(HardZero && (rsvReg == '0));
  end

  // Read port 1 source selection (zero register, optional forwarding, array).
  always_comb begin
    readData1 = regs[readReg1];
    if (HardZero && (readReg1 == '0)) begin
      readData1 = '0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (writeStore && (readReg1 == writeReg)) begin
      readData1 = mergedData;
    end
`endif
  end

  // Read port 2 source selection, mirroring port 1.
  always_comb begin
    readData2 = regs[readReg2];
    if (HardZero && (readReg2 == '0)) begin
      readData2 = '0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (writeStore && (readReg2 == writeReg)) begin
      readData2 = mergedData;
    end
`endif
  end

  // Scoreboard next state: the write clears first so a same-edge reserve wins.
  always_comb begin
    busyNext = busy;
    if (writeAny) begin
      busyNext[writeReg] = 1'b0;
    end
    if (rsvSet) begin
      busyNext[rsvReg] = 1'b1;
    end
  end

  // Register array storage with asynchronous clear.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (writeStore) begin
      regs[writeReg] <= mergedData;
    end
  end

  // Scoreboard state.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busyNext;
    end
  end

  // Registered read data; held while no read is strobed.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      outReg1  <= '0;
      outReg2  <= '0;
      outValid <= 1'b0;
    end else begin
      outValid <= readEn;
      if (readEn) begin
        outReg1 <= readData1;
        outReg2 <= readData2;
      end
    end
  end

  // Busy lookups follow the read indices combinationally.
  always_comb begin
    busy1 = busy[readReg1];
    busy2 = busy[readReg2];
  end

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: one default instance (32b x 32, zero reg)
// and two narrow instances (16b x 8) with and without the zero register,
// all checked against an array-based reference model.

module tb_register_file_param;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CLK = 1'b0;
  logic reset;

  logic [4:0]  rr1, rr2, wrReg, rsvReg;
  logic        rdEn, wrEn, rsvEn;
  logic [31:0] wData;
  logic [3:0]  bEn;
  logic [31:0] o1, o2;
  logic        ov, b1, b2;

  logic [2:0]  sR1, sR2, sWr, sRsv;
  logic        sRd, sWe, sRs;
  logic [15:0] sWd;
  logic [1:0]  sBe;
  logic [15:0] s1a, s2a, s1b, s2b;
  logic        sva, svb, sb1a, sb2a, sb1b, sb2b;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  register_file_param dut (
    .CLK(CLK), .reset(reset), .readReg1(rr1), .readReg2(rr2), .readEn(rdEn),
    .writeReg(wrReg), .writeEn(wrEn), .writeData(wData), .byteEn(bEn),
    .rsvEn(rsvEn), .rsvReg(rsvReg), .outReg1(o1), .outReg2(o2),
    .outValid(ov), .busy1(b1), .busy2(b2));

  register_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dutS (
    .CLK(CLK), .reset(reset), .readReg1(sR1), .readReg2(sR2), .readEn(sRd),
    .writeReg(sWr), .writeEn(sWe), .writeData(sWd), .byteEn(sBe),
    .rsvEn(sRs), .rsvReg(sRsv), .outReg1(s1a), .outReg2(s2a),
    .outValid(sva), .busy1(sb1a), .busy2(sb2a));

  register_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) dutN (
    .CLK(CLK), .reset(reset), .readReg1(sR1), .readReg2(sR2), .readEn(sRd),
    .writeReg(sWr), .writeEn(sWe), .writeData(sWd), .byteEn(sBe),
    .rsvEn(sRs), .rsvReg(sRsv), .outReg1(s1b), .outReg2(s2b),
    .outValid(svb), .busy1(sb1b), .busy2(sb2b));

  // Reference model: index 0 = default instance, 1 = narrow zero-reg, 2 = narrow plain.
  logic [31:0] mReg  [3][32];
  bit          mBusy [3][32];
  logic [31:0] mOut1 [3];
  logic [31:0] mOut2 [3];
  bit          mValid[3];
  int          mW[3] = '{32, 16, 16};
  bit          mZ[3] = '{1'b1, 1'b1, 1'b0};

  function automatic logic [31:0] mRead(int k, int idx);
    if (mZ[k] && idx == 0) return 32'h0;
    return mReg[k][idx];
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 32; i++) begin
        mReg[k][i]  = 32'h0;
        mBusy[k][i] = 1'b0;
      end
      mOut1[k]  = 32'h0;
      mOut2[k]  = 32'h0;
      mValid[k] = 1'b0;
    end
  endtask

  task automatic modelStep(int k, bit re, int r1, int r2, bit we, int wr,
                           logic [31:0] wd, int be, bit rs, int rsr);
    logic [31:0] mask;
    logic [31:0] nv;
    bit          stores;
    mask = 32'h0;
    for (int b = 0; b < mW[k] / 8; b++) begin
      if (be[b]) mask = mask | (32'hFF << (8 * b));
    end
    stores = we && (be != 0) && !(mZ[k] && wr == 0);
    nv = (mReg[k][wr] & ~mask) | (wd & mask);
    if (re) begin
      mOut1[k] = (BYP && stores && r1 == wr) ? nv : mRead(k, r1);
      mOut2[k] = (BYP && stores && r2 == wr) ? nv : mRead(k, r2);
    end
    mValid[k] = re;
    if (stores) mReg[k][wr] = nv;
    if (we && be != 0) mBusy[k][wr] = 1'b0;
    if (rs && !(mZ[k] && rsr == 0)) mBusy[k][rsr] = 1'b1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    chk("big_out1",  o1, mOut1[0]);
    chk("big_out2",  o2, mOut2[0]);
    chk("big_valid", {31'b0, ov}, {31'b0, mValid[0]});
    chk("big_busy1", {31'b0, b1}, {31'b0, mBusy[0][int'(rr1)]});
    chk("big_busy2", {31'b0, b2}, {31'b0, mBusy[0][int'(rr2)]});
    chk("zr_out1",   {16'b0, s1a}, mOut1[1]);
    chk("zr_out2",   {16'b0, s2a}, mOut2[1]);
    chk("zr_valid",  {31'b0, sva}, {31'b0, mValid[1]});
    chk("zr_busy1",  {31'b0, sb1a}, {31'b0, mBusy[1][int'(sR1)]});
    chk("zr_busy2",  {31'b0, sb2a}, {31'b0, mBusy[1][int'(sR2)]});
    chk("nz_out1",   {16'b0, s1b}, mOut1[2]);
    chk("nz_out2",   {16'b0, s2b}, mOut2[2]);
    chk("nz_valid",  {31'b0, svb}, {31'b0, mValid[2]});
    chk("nz_busy1",  {31'b0, sb1b}, {31'b0, mBusy[2][int'(sR1)]});
    chk("nz_busy2",  {31'b0, sb2b}, {31'b0, mBusy[2][int'(sR2)]});
  endtask

  task automatic tick();
    modelStep(0, rdEn, int'(rr1), int'(rr2), wrEn, int'(wrReg), wData,
              int'(bEn), rsvEn, int'(rsvReg));
    for (int k = 1; k < 3; k++) begin
      modelStep(k, sRd, int'(sR1), int'(sR2), sWe, int'(sWr), {16'b0, sWd},
                int'(sBe), sRs, int'(sRsv));
    end
    @(posedge CLK);
    #1;
    checkAll();
  endtask

  task automatic idle();
    rdEn = 1'b0; wrEn = 1'b0; rsvEn = 1'b0; bEn = 4'h0;
    sRd  = 1'b0; sWe  = 1'b0; sRs   = 1'b0; sBe = 2'h0;
  endtask

  task automatic randomize_inputs();
    rr1 = 5'($urandom);  rr2 = 5'($urandom);  wrReg = 5'($urandom % 8);
    rsvReg = 5'($urandom % 8);
    rdEn = ($urandom_range(0, 3) != 0);
    wrEn = ($urandom_range(0, 1) != 0);
    rsvEn = ($urandom_range(0, 3) == 0);
    wData = $urandom;  bEn = 4'($urandom);
    sR1 = 3'($urandom); sR2 = 3'($urandom); sWr = 3'($urandom); sRsv = 3'($urandom);
    sRd = ($urandom_range(0, 3) != 0);
    sWe = ($urandom_range(0, 1) != 0);
    sRs = ($urandom_range(0, 3) == 0);
    sWd = 16'($urandom); sBe = 2'($urandom);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    rr1 = '0; rr2 = '0; wrReg = '0; rsvReg = '0; wData = '0;
    sR1 = '0; sR2 = '0; sWr = '0; sRsv = '0; sWd = '0;
    modelReset();
    #2;
    checkAll();
    @(posedge CLK);
    #1;
    reset = 1'b0;

    // Byte-enable merge on r5.
    wrEn = 1'b1; wrReg = 5'd5; wData = 32'hDEADBEEF; bEn = 4'b1111; tick();
    wData = 32'h000055AA; bEn = 4'b0010; tick();
    idle(); rdEn = 1'b1; rr1 = 5'd5; rr2 = 5'd5; tick();
    chk("r5_merge", o1, 32'hDEAD55EF);
    chk("r5_valid", {31'b0, ov}, 32'd1);
    idle(); tick();
    chk("valid_drop", {31'b0, ov}, 32'd0);
    chk("read_hold", o1, 32'hDEAD55EF);

    // Zero register: write and reserve are both ignored.
    wrEn = 1'b1; wrReg = 5'd0; wData = 32'hFFFFFFFF; bEn = 4'hF;
    rsvEn = 1'b1; rsvReg = 5'd0; tick();
    idle(); rdEn = 1'b1; rr1 = 5'd0; tick();
    chk("r0_read", o1, 32'h0);
    chk("r0_busy", {31'b0, b1}, 32'd0);

    // Same-edge write and read of r7.
    idle(); rdEn = 1'b1; rr1 = 5'd7; wrEn = 1'b1; wrReg = 5'd7;
    wData = 32'h12345678; bEn = 4'hF; tick();
    chk("raw_r7", o1, BYP ? 32'h12345678 : 32'h0);
    idle(); rdEn = 1'b1; rr1 = 5'd7; tick();
    chk("r7_next", o1, 32'h12345678);

    // Scoreboard on r9.
    idle(); rr2 = 5'd9; rsvEn = 1'b1; rsvReg = 5'd9; tick();
    chk("busy9_set", {31'b0, b2}, 32'd1);
    idle(); wrEn = 1'b1; wrReg = 5'd9; wData = 32'hCAFE0009; bEn = 4'hF; tick();
    chk("busy9_clr", {31'b0, b2}, 32'd0);
    rsvEn = 1'b1; rsvReg = 5'd9; tick();
    chk("busy9_both", {31'b0, b2}, 32'd1);

    // Random traffic on all instances.
    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      tick();
    end

    // Mid-run reset pulse with all strobes active.
    #2;
    randomize_inputs();
    rdEn = 1'b1; wrEn = 1'b1; rsvEn = 1'b1; bEn = 4'hF;
    sRd = 1'b1; sWe = 1'b1; sRs = 1'b1; sBe = 2'h3;
    reset = 1'b1;
    #1;
    modelReset();
    checkAll();
    chk("rst_out1", o1, 32'h0);
    chk("rst_valid", {31'b0, ov}, 32'd0);
    @(posedge CLK);
    #1;
    checkAll();
    reset = 1'b0;
    idle();
    for (int i = 1; i < 32; i++) begin
      rdEn = 1'b1; rr1 = 5'(i); rr2 = 5'(32 - i); tick();
      chk("postrst_read", o1, 32'h0);
    end

    // Narrow instances: fill all eight registers, then read pairs.
    idle();
    for (int i = 0; i < 8; i++) begin
      sWe = 1'b1; sWr = 3'(i); sWd = 16'hA000 + 16'(i * 16'h111); sBe = 2'b11;
      tick();
    end
    idle(); sRd = 1'b1; sR1 = 3'd0; sR2 = 3'd7; tick();
    chk("narrow_zr_r0", {16'b0, s1a}, 32'h0);
    chk("narrow_zr_r7", {16'b0, s2a}, 32'h0000A777);
    chk("narrow_nz_r0", {16'b0, s1b}, 32'h0000A000);
    sR1 = 3'd3; sR2 = 3'd4; tick();
    chk("narrow_r3", {16'b0, s1a}, 32'h0000A333);
    chk("narrow_r4", {16'b0, s2b}, 32'h0000A444);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_param.md
REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width; legal values are multiples of 8 and at least 8.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter ZERO_REG, default 1; when 1, register 0 is hardwired to zero.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports named CLK and reset.
REQ-005 SHALL have port CLK  input  1  clock; all state updates occur on the rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-007 SHALL have ports readReg1 and readReg2  input  ADDR_W  read port indices.
REQ-008 SHALL have port readEn  input  1  read strobe shared by both read ports.
REQ-009 SHALL have port writeReg  input  ADDR_W  write index.
REQ-010 SHALL have port writeEn  input  1  write strobe.
REQ-011 SHALL have port writeData  input  DATA_W  write data.
REQ-012 SHALL have port byteEn  input  DATA_W/8  per-byte write enable; bit k qualifies writeData[8k+7:8k].
REQ-013 SHALL have port rsvEn  input  1  scoreboard reserve strobe.
REQ-014 SHALL have port rsvReg  input  ADDR_W  register to mark pending.
REQ-015 SHALL have ports outReg1 and outReg2  output  DATA_W  registered read data.
REQ-016 SHALL have port outValid  output  1  high for one cycle after each readEn cycle.
REQ-017 SHALL have ports busy1 and busy2  output  1  combinational scoreboard bit for readReg1 and readReg2.

Function
REQ-018 SHALL write the enabled bytes of writeData into registers[writeReg] on an edge with writeEn=1; bytes with byteEn=0 keep their old value.
REQ-019 SHALL leave all registers unchanged when writeEn=0, or when byteEn is all zero.
REQ-020 SHALL ignore writes to index 0 and return 0 for any read of index 0 when ZERO_REG=1; when ZERO_REG=0, index 0 SHALL behave as a normal register.
REQ-021 SHALL load outReg1/outReg2 from registers[readReg1]/registers[readReg2] on an edge with readEn=1, giving 1-cycle read latency.
REQ-022 SHALL set outValid equal to the readEn value sampled at the previous edge.
REQ-023 SHALL hold outReg1/outReg2 at their last values while readEn=0.
REQ-024 SHALL keep one busy bit per register.
REQ-025 SHALL set busy[rsvReg] on an edge with rsvEn=1.
REQ-026 SHALL clear busy[writeReg] on an edge with writeEn=1 and a nonzero byteEn.
REQ-027 SHALL let the set win when rsvEn and a write target the same register on the same edge, so busy ends at 1.
REQ-028 SHALL never set busy[0] when ZERO_REG=1.
REQ-029 SHALL drive busy1=busy[readReg1] and busy2=busy[readReg2] combinationally from the current state.
REQ-030 SHALL apply read-after-write behaviour per the Configuration section when readEn and writeEn hit the same index on the same edge.

Reset
REQ-031 SHALL, while reset=1, immediately and independently of CLK clear every register to 0.
REQ-032 SHALL, while reset=1, clear every busy bit, outReg1, outReg2 and outValid to 0.
REQ-033 SHALL ignore readEn, writeEn and rsvEn while reset=1.
REQ-034 SHALL drop an operation asserted on the same edge that reset deasserts only if reset is still high at that edge.

Configuration
REQ-035 SHALL, with macro REGFILE_BYPASS_EN defined, forward the byte-merged new value to outRegN in the same edge when readEn, writeEn and readRegN==writeReg coincide (old bytes where byteEn=0), except for index 0 when ZERO_REG=1.
REQ-036 SHALL, without REGFILE_BYPASS_EN, return the pre-write value to outRegN in that case; the new value is visible on the next read.

Verification
REQ-037 Bench SHALL cover: reset pulse mid-run after writes -> all outReg*, outValid and busy* read 0, and any later read of r1..r31 returns 0.
REQ-038 Bench SHALL cover: write r5=0xDEADBEEF with byteEn=4'b1111, then byteEn=4'b0010 with data 0x000055AA -> reading r5 gives 0xDEAD55EF one cycle later with outValid=1.
REQ-039 Bench SHALL cover: ZERO_REG=1, write r0=0xFFFFFFFF and rsvEn on r0 -> outReg1=0 and busy1=0 on reading r0.
REQ-040 Bench SHALL cover: same-edge write r7=0x12345678 and read r7 with old value 0x0 -> outReg1=0x12345678 with REGFILE_BYPASS_EN, 0x0 without it.
REQ-041 Bench SHALL cover: rsvEn r9 -> busy2=1 with readReg2=9; write r9 -> busy2=0; rsvEn and write r9 on the same edge -> busy2=1.
REQ-042 Bench SHALL cover: DATA_W=16, ADDR_W=3 instance, write all 8 registers then read pairs (0,7), (3,4) -> correct values, with r0 equal to 0 when ZERO_REG=1.
